// File: rtl/hazard_forward_unit_pkg.sv
// rtl/hazard_forward_unit_pkg.sv - shared select encodings and pipeline stage-entry types
package hazard_forward_unit_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef struct packed {
    logic      valid;
    reg_addr_t rs;
    reg_addr_t rt;
    logic      uses_rs;
    logic      uses_rt;
    reg_addr_t dst;
    logic      reg_write;
    logic      mem_read;
  } ex_entry_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t dst;
    logic      reg_write;
    logic      mem_read;
  } mem_entry_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t dst;
    logic      reg_write;
  } wb_entry_t;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// rtl/hazard_forward_unit_fwd_select.sv - single EX operand forward-select priority logic
module fwd_select
  import hazard_forward_unit_pkg::*;
(
  input  logic       ex_valid,
  input  logic       uses_src,
  input  reg_addr_t  src,
  input  mem_entry_t mem_entry,
  input  wb_entry_t  wb_entry,
  output logic [1:0] fwd_sel
);

  logic operand_live;
  logic mem_hit;
  logic wb_hit;

  always_comb begin
    operand_live = ex_valid & uses_src & (src != REG_ZERO);
    // A load in MEM has no result on the EX/MEM ALU path yet; only its WB copy may forward.
    mem_hit = operand_live & mem_entry.valid & mem_entry.reg_write &
              ~mem_entry.mem_read & (mem_entry.dst == src);
    wb_hit  = operand_live & wb_entry.valid & wb_entry.reg_write & (wb_entry.dst == src);
    fwd_sel = FWD_REGFILE;
    if (mem_hit) begin
      fwd_sel = FWD_EXMEM;
    end else if (wb_hit) begin
      fwd_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - EX operand forwarding selects and load-use stall for the 5-stage pipeline
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_AW,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      IdValid,
  input  logic [REG_ADDR_WIDTH-1:0] IdRs,
  input  logic [REG_ADDR_WIDTH-1:0] IdRt,
  input  logic                      IdUsesRs,
  input  logic                      IdUsesRt,
  input  logic [REG_ADDR_WIDTH-1:0] IdWriteReg,
  input  logic                      IdRegWrite,
  input  logic                      IdMemRead,
  input  logic                      Flush,
  input  logic                      Freeze,
  output logic [1:0]                ForwardA,
  output logic [1:0]                ForwardB,
  output logic                      Stall,
  output logic [CNT_WIDTH-1:0]      StallCount
);

  ex_entry_t            ex_q, ex_d;
  mem_entry_t           mem_q, mem_d;
  wb_entry_t            wb_q, wb_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  ex_entry_t id_entry;
  logic      load_in_ex;
  logic      rs_hit;
  logic      rt_hit;
  logic      stall;

  always_comb begin
    id_entry.valid     = IdValid;
    id_entry.rs        = IdRs;
    id_entry.rt        = IdRt;
    id_entry.uses_rs   = IdUsesRs;
    id_entry.uses_rt   = IdUsesRt;
    id_entry.dst       = IdWriteReg;
    id_entry.reg_write = IdRegWrite;
    id_entry.mem_read  = IdMemRead;

    load_in_ex = ex_q.valid & ex_q.mem_read & ex_q.reg_write & (ex_q.dst != REG_ZERO);
    rs_hit     = IdUsesRs & (IdRs == ex_q.dst);
    rt_hit     = IdUsesRt & (IdRt == ex_q.dst);
    // A taken branch kills the ID instruction, so there is nothing left to protect.
    stall      = IdValid & ~Flush & load_in_ex & (rs_hit | rt_hit);
  end

  always_comb begin
    ex_d          = ex_q;
    mem_d         = mem_q;
    wb_d          = wb_q;
    stall_count_d = stall_count_q;
    if (!Freeze) begin
      wb_d.valid      = mem_q.valid;
      wb_d.dst        = mem_q.dst;
      wb_d.reg_write  = mem_q.reg_write;

      mem_d.valid     = ex_q.valid;
      mem_d.dst       = ex_q.dst;
      mem_d.reg_write = ex_q.reg_write;
      mem_d.mem_read  = ex_q.mem_read;

      if (IdValid && !stall && !Flush) begin
        ex_d = id_entry;
      end else begin
        ex_d = '0;
      end

      if (stall && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
        stall_count_d = stall_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  fwd_select u_fwd_a (
    .ex_valid  (ex_q.valid),
    .uses_src  (ex_q.uses_rs),
    .src       (ex_q.rs),
    .mem_entry (mem_q),
    .wb_entry  (wb_q),
    .fwd_sel   (ForwardA)
  );

  fwd_select u_fwd_b (
    .ex_valid  (ex_q.valid),
    .uses_src  (ex_q.uses_rt),
    .src       (ex_q.rt),
    .mem_entry (mem_q),
    .wb_entry  (wb_q),
    .fwd_sel   (ForwardB)
  );

  assign Stall      = stall;
  assign StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - scoreboard bench with an in-order instruction-window reference model
module tb_hazard_forward_unit;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        IdValid;
  logic [4:0]  IdRs;
  logic [4:0]  IdRt;
  logic        IdUsesRs;
  logic        IdUsesRt;
  logic [4:0]  IdWriteReg;
  logic        IdRegWrite;
  logic        IdMemRead;
  logic        Flush;
  logic        Freeze;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic        Stall;
  logic [15:0] StallCount;

  always #5 Clk = ~Clk;

  hazard_forward_unit dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .IdValid    (IdValid),
    .IdRs       (IdRs),
    .IdRt       (IdRt),
    .IdUsesRs   (IdUsesRs),
    .IdUsesRt   (IdUsesRt),
    .IdWriteReg (IdWriteReg),
    .IdRegWrite (IdRegWrite),
    .IdMemRead  (IdMemRead),
    .Flush      (Flush),
    .Freeze     (Freeze),
    .ForwardA   (ForwardA),
    .ForwardB   (ForwardB),
    .Stall      (Stall),
    .StallCount (StallCount)
  );

  typedef struct {
    bit valid;
    int rs;
    int rt;
    bit urs;
    bit urt;
    int dst;
    bit wr;
    bit ld;
  } instr_t;

  typedef struct {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic [15:0] cnt;
    int          id;
  } exp_t;

  // window[0] is the instruction in EX, window[1] the one ahead of it, window[2] two ahead
  instr_t      window [3];
  int unsigned m_count;
  bit          m_known = 1'b0;
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          step_no = 0;
  bit          stim_done = 1'b0;

  function automatic instr_t mk(bit v, int rs, int rt, bit urs, bit urt, int dst, bit wr, bit ld);
    instr_t i;
    i.valid = v; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    i.dst = dst; i.wr = wr; i.ld = ld;
    return i;
  endfunction

  function automatic instr_t alu(int dst, int rs, int rt);
    return mk(1'b1, rs, rt, 1'b1, 1'b1, dst, 1'b1, 1'b0);
  endfunction

  function automatic instr_t lw(int dst, int base);
    return mk(1'b1, base, 0, 1'b1, 1'b0, dst, 1'b1, 1'b1);
  endfunction

  function automatic instr_t nop_i();
    return mk(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endfunction

  function automatic instr_t bubble();
    return mk(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endfunction

  // Newest producer of r wins; a load one slot ahead has no value to forward yet.
  function automatic logic [1:0] model_fwd(int r, bit uses);
    if (!window[0].valid || !uses || r == 0) return 2'b00;
    for (int d = 1; d <= 2; d++) begin
      if (window[d].valid && window[d].wr && window[d].dst == r && !(d == 1 && window[d].ld))
        return (d == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic bit model_stall(instr_t id, bit flush);
    instr_t p;
    p = window[0];
    if (!id.valid || flush) return 1'b0;
    if (!(p.valid && p.ld && p.wr && p.dst != 0)) return 1'b0;
    return (id.urs && id.rs == p.dst) || (id.urt && id.rt == p.dst);
  endfunction

  task automatic step(instr_t id, bit flush, bit freeze, bit rst_n);
    exp_t e;
    bit   st;
    @(negedge Clk);
    step_no++;
    Reset_n    = rst_n;
    IdValid    = id.valid;
    IdRs       = 5'(id.rs);
    IdRt       = 5'(id.rt);
    IdUsesRs   = id.urs;
    IdUsesRt   = id.urt;
    IdWriteReg = 5'(id.dst);
    IdRegWrite = id.wr;
    IdMemRead  = id.ld;
    Flush      = flush;
    Freeze     = freeze;
    st = model_stall(id, flush);
    if (m_known) begin
      e.fa  = model_fwd(window[0].rs, window[0].urs);
      e.fb  = model_fwd(window[0].rt, window[0].urt);
      e.st  = st;
      e.cnt = 16'(m_count);
      e.id  = step_no;
      exp_q.push_back(e);
    end
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) window[k] = bubble();
      m_count = 0;
      m_known = 1'b1;
    end else if (!freeze) begin
      if (st && m_count < 65535) m_count++;
      window[2] = window[1];
      window[1] = window[0];
      window[0] = (id.valid && !st && !flush) ? id : bubble();
    end
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp, int id);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ForwardA",   16'(ForwardA), 16'(e.fa), e.id);
        chk("ForwardB",   16'(ForwardB), 16'(e.fb), e.id);
        chk("Stall",      16'(Stall),    16'(e.st), e.id);
        chk("StallCount", StallCount,    e.cnt,     e.id);
      end
    end
  end

  initial begin : stimulus
    instr_t id;
    Reset_n = 1'b0; IdValid = 1'b0; IdRs = '0; IdRt = '0; IdUsesRs = 1'b0; IdUsesRt = 1'b0;
    IdWriteReg = '0; IdRegWrite = 1'b0; IdMemRead = 1'b0; Flush = 1'b0; Freeze = 1'b0;

    step(alu(3, 1, 2), 0, 0, 0);
    step(alu(3, 1, 2), 0, 0, 0);

    step(alu(3, 1, 2), 0, 0, 1);
    step(alu(4, 3, 5), 0, 0, 1);
    step(nop_i(), 0, 0, 1);

    step(alu(3, 1, 2), 0, 0, 1);
    step(nop_i(), 0, 0, 1);
    step(alu(4, 3, 3), 0, 0, 1);
    step(nop_i(), 0, 0, 1);

    step(alu(3, 1, 2), 0, 0, 1);
    step(alu(3, 4, 5), 0, 0, 1);
    step(alu(6, 3, 3), 0, 0, 1);
    step(nop_i(), 0, 0, 1);

    step(lw(5, 1), 0, 0, 1);
    step(alu(6, 5, 2), 0, 0, 1);
    step(alu(6, 5, 2), 0, 0, 1);
    step(nop_i(), 0, 0, 1);
    step(nop_i(), 0, 0, 1);

    step(lw(5, 1), 0, 0, 1);
    step(alu(6, 5, 2), 0, 1, 1);
    step(alu(6, 5, 2), 0, 1, 1);
    step(alu(6, 5, 2), 0, 0, 1);
    step(alu(6, 5, 2), 0, 0, 1);
    step(nop_i(), 0, 0, 1);
    step(nop_i(), 0, 0, 1);

    step(alu(0, 1, 2), 0, 0, 1);
    step(alu(4, 0, 0), 0, 0, 1);
    step(nop_i(), 0, 0, 1);
    step(lw(5, 1), 0, 0, 1);
    step(alu(6, 5, 2), 1, 0, 1);
    step(nop_i(), 0, 0, 1);

    step(alu(3, 1, 2), 0, 0, 1);
    step(alu(4, 3, 3), 0, 0, 0);
    step(alu(7, 3, 4), 0, 0, 1);
    step(nop_i(), 0, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      id.valid = ($urandom_range(0, 99) < 85);
      id.ld    = ($urandom_range(0, 3) == 0);
      id.rs    = $urandom_range(0, 7);
      id.rt    = $urandom_range(0, 7);
      id.urs   = ($urandom_range(0, 5) != 0);
      id.urt   = id.ld ? 1'b0 : ($urandom_range(0, 2) != 0);
      id.dst   = $urandom_range(0, 7);
      id.wr    = id.ld ? 1'b1 : ($urandom_range(0, 4) != 0);
      step(id, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 199) != 0);
    end

    repeat (3) @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
